// File: rtl/ysyx_22040895_stu_if.sv
// Store-unit bus: EX/MEM store request side plus the data-memory write port.
interface ysyx_22040895_stu_if #(
    parameter int XLEN = 64,
    parameter int AW   = 64
);
    logic            valid_i_stu;
    logic            ready_o_stu;
    logic [AW-1:0]   addr_i_stu;
    logic [XLEN-1:0] data_i_stu;
    logic [1:0]      size_i_stu;
    logic            mem_req_o_stu;
    logic [AW-1:0]   mem_addr_o_stu;
    logic [XLEN-1:0] mem_wdata_o_stu;
    logic [7:0]      mem_wmask_o_stu;
    logic            mem_ack_i_stu;
    logic            done_o_stu;

    modport slave (
        input  valid_i_stu, addr_i_stu, data_i_stu, size_i_stu, mem_ack_i_stu,
        output ready_o_stu, mem_req_o_stu, mem_addr_o_stu, mem_wdata_o_stu,
               mem_wmask_o_stu, done_o_stu
    );

    modport master (
        output valid_i_stu, addr_i_stu, data_i_stu, size_i_stu, mem_ack_i_stu,
        input  ready_o_stu, mem_req_o_stu, mem_addr_o_stu, mem_wdata_o_stu,
               mem_wmask_o_stu, done_o_stu
    );
endinterface

// File: rtl/ysyx_22040895_stu.sv
// Store narrowing: lane-aligns sb/sh/sw/sd into one or two 8-byte beats; req one cycle after accept.
// Beats wait on mem_ack; ready is low from accept until the cycle after the done pulse.
module ysyx_22040895_stu #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_22040895_stu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
        logic [7:0]      mask;
    } beat_t;

    // Shifting into a double-width window yields both beats at once: low half is
    // beat0, high half is what spilled past the 8-byte boundary.
    function automatic beat_t f_beat(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                                     input logic [1:0] s, input logic hi);
        beat_t             b;
        logic [7:0]        base;
        logic [15:0]       m;
        logic [2*XLEN-1:0] w;
        logic [AW-1:0]     ba;
        case (s)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        ba = {a[AW-1:3], 3'b000};
        m  = {8'h00, base} << a[2:0];
        w  = {{XLEN{1'b0}}, d} << {a[2:0], 3'b000};
        if (hi) begin
            b.addr  = ba + AW'(8);
            b.wdata = w[2*XLEN-1:XLEN];
            b.mask  = m[15:8];
        end else begin
            b.addr  = ba;
            b.wdata = w[XLEN-1:0];
            b.mask  = m[7:0];
        end
        return b;
    endfunction

    state_t          r_state, w_nstate;
    logic [AW-1:0]   r_addr, w_naddr;
    logic [XLEN-1:0] r_data, w_ndata;
    logic [1:0]      r_size, w_nsize;
    logic            r_ready, w_nready;
    logic            r_req, w_nreq;
    logic            r_done, w_ndone;
    beat_t           r_beat, w_nbeat;
    beat_t           w_b0, w_b1;
    logic            w_split;

    assign w_b0    = f_beat(bus.addr_i_stu, bus.data_i_stu, bus.size_i_stu, 1'b0);
    assign w_b1    = f_beat(r_addr, r_data, r_size, 1'b1);
    assign w_split = ({1'b0, r_addr[2:0]} + (4'd1 << r_size)) > 4'd8;

    always_comb begin
        w_nstate = r_state;
        w_naddr  = r_addr;
        w_ndata  = r_data;
        w_nsize  = r_size;
        w_nready = r_ready;
        w_nreq   = r_req;
        w_ndone  = 1'b0;
        w_nbeat  = r_beat;
        case (r_state)
            IDLE: begin
                w_nready = 1'b1;
                w_nreq   = 1'b0;
                w_nbeat.mask = 8'h00;
                if (bus.valid_i_stu) begin
                    w_naddr  = bus.addr_i_stu;
                    w_ndata  = bus.data_i_stu;
                    w_nsize  = bus.size_i_stu;
                    w_nbeat  = w_b0;
                    w_nreq   = 1'b1;
                    w_nready = 1'b0;
                    w_nstate = BEAT0;
                end
            end
            BEAT0: begin
                if (bus.mem_ack_i_stu) begin
                    if (w_split) begin
                        w_nbeat  = w_b1;
                        w_nstate = BEAT1;
                    end else begin
                        w_nreq       = 1'b0;
                        w_nbeat.mask = 8'h00;
                        w_ndone      = 1'b1;
                        w_nstate     = DONE;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ack_i_stu) begin
                    w_nreq       = 1'b0;
                    w_nbeat.mask = 8'h00;
                    w_ndone      = 1'b1;
                    w_nstate     = DONE;
                end
            end
            default: begin
                w_nready = 1'b1;
                w_nstate = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_beat  <= '0;
        end else begin
            r_state <= w_nstate;
            r_addr  <= w_naddr;
            r_data  <= w_ndata;
            r_size  <= w_nsize;
            r_ready <= w_nready;
            r_req   <= w_nreq;
            r_done  <= w_ndone;
            r_beat  <= w_nbeat;
        end
    end

    assign bus.ready_o_stu     = r_ready;
    assign bus.mem_req_o_stu   = r_req;
    assign bus.mem_addr_o_stu  = r_beat.addr;
    assign bus.mem_wdata_o_stu = r_beat.wdata;
    assign bus.mem_wmask_o_stu = r_beat.mask;
    assign bus.done_o_stu      = r_done;
endmodule

// File: tb/tb_ysyx_22040895_stu.sv
// Directed bench for the store-narrowing unit: vector table with zero-wait ack plus wait-state/reset sequences.
module tb_ysyx_22040895_stu;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    ysyx_22040895_stu_if #(.XLEN(64), .AW(64)) bus ();

    ysyx_22040895_stu #(.XLEN(64), .AW(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic        split;
        logic [63:0] a0;
        logic [7:0]  m0;
        logic [63:0] d0;
        logic [63:0] a1;
        logic [7:0]  m1;
        logic [63:0] d1;
    } vec_t;

    vec_t vt[10];

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input logic [63:0] a, input logic [7:0] m,
                            input logic [63:0] d);
        chk({name, ".req"},   64'(bus.mem_req_o_stu), 64'd1);
        chk({name, ".addr"},  bus.mem_addr_o_stu, a);
        chk({name, ".mask"},  64'(bus.mem_wmask_o_stu), 64'(m));
        chk({name, ".wdata"}, bus.mem_wdata_o_stu & lanes(m), d & lanes(m));
        chk({name, ".ready"}, 64'(bus.ready_o_stu), 64'd0);
        chk({name, ".done"},  64'(bus.done_o_stu), 64'd0);
    endtask

    task automatic chk_done(input string name);
        chk({name, ".done"},    64'(bus.done_o_stu), 64'd1);
        chk({name, ".req_lo"},  64'(bus.mem_req_o_stu), 64'd0);
        chk({name, ".mask_lo"}, 64'(bus.mem_wmask_o_stu), 64'd0);
        chk({name, ".rdy_lo"},  64'(bus.ready_o_stu), 64'd0);
    endtask

    // Called right after a negedge; leaves the bench at the negedge where ready is high again.
    task automatic run_vec(input string name, input vec_t v);
        bus.valid_i_stu = 1'b1;
        bus.addr_i_stu  = v.addr;
        bus.data_i_stu  = v.data;
        bus.size_i_stu  = v.size;
        @(negedge clk);
        bus.valid_i_stu = 1'b0;
        chk_beat({name, ".b0"}, v.a0, v.m0, v.d0);
        if (v.split) begin
            @(negedge clk);
            chk_beat({name, ".b1"}, v.a1, v.m1, v.d1);
        end
        @(negedge clk);
        chk_done(name);
        @(negedge clk);
        chk({name, ".done_clr"}, 64'(bus.done_o_stu), 64'd0);
        chk({name, ".rdy_hi"},   64'(bus.ready_o_stu), 64'd1);
    endtask

    int   dones;
    vec_t vs;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        bus.valid_i_stu   = 1'b0;
        bus.addr_i_stu    = '0;
        bus.data_i_stu    = '0;
        bus.size_i_stu    = '0;
        bus.mem_ack_i_stu = 1'b1;

        vt[0] = '{64'h8000_0000, 64'h1122334455667788, 2'd3, 1'b0,
                  64'h8000_0000, 8'hFF, 64'h1122334455667788, 64'h0, 8'h00, 64'h0};
        vt[1] = '{64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 1'b0,
                  64'h8000_0000, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 8'h00, 64'h0};
        vt[2] = '{64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b1,
                  64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h8000_0008, 8'h03, 64'hDEAD};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0102030405060708, 2'd3, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFF8, 8'hF0, 64'h0506_0708_0000_0000, 64'h0, 8'h0F, 64'h0102_0304};
        vt[4] = '{64'h13, 64'hABCD, 2'd1, 1'b0,
                  64'h10, 8'h18, 64'h0000_00AB_CD00_0000, 64'h0, 8'h00, 64'h0};
        vt[5] = '{64'h7, 64'h55AA, 2'd1, 1'b1,
                  64'h0, 8'h80, 64'hAA00_0000_0000_0000, 64'h8, 8'h01, 64'h55};
        vt[6] = '{64'h101, 64'h8877665544332211, 2'd3, 1'b1,
                  64'h100, 8'hFE, 64'h7766_5544_3322_1100, 64'h108, 8'h01, 64'h88};
        vt[7] = '{64'h24, 64'hFFFF_FFFF_CAFE_F00D, 2'd2, 1'b0,
                  64'h20, 8'hF0, 64'hCAFE_F00D_0000_0000, 64'h0, 8'h00, 64'h0};
        vt[8] = '{64'hF, 64'h5A, 2'd0, 1'b0,
                  64'h8, 8'h80, 64'h5A00_0000_0000_0000, 64'h0, 8'h00, 64'h0};
        vt[9] = '{64'h2, 64'h1234, 2'd1, 1'b0,
                  64'h0, 8'h0C, 64'h0000_0000_1234_0000, 64'h0, 8'h00, 64'h0};

        @(negedge clk);
        @(negedge clk);
        chk("rst.ready", 64'(bus.ready_o_stu), 64'd1);
        chk("rst.req",   64'(bus.mem_req_o_stu), 64'd0);
        chk("rst.addr",  bus.mem_addr_o_stu, 64'd0);
        chk("rst.wdata", bus.mem_wdata_o_stu, 64'd0);
        chk("rst.mask",  64'(bus.mem_wmask_o_stu), 64'd0);
        chk("rst.done",  64'(bus.done_o_stu), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Ack high while idle must not start anything.
        chk("idle_ack.req",  64'(bus.mem_req_o_stu), 64'd0);
        chk("idle_ack.done", 64'(bus.done_o_stu), 64'd0);

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Split sw with three wait cycles per beat and a stray valid mid-transaction.
        vs = vt[2];
        bus.mem_ack_i_stu = 1'b0;
        bus.valid_i_stu   = 1'b1;
        bus.addr_i_stu    = vs.addr;
        bus.data_i_stu    = vs.data;
        bus.size_i_stu    = vs.size;
        @(negedge clk);
        bus.valid_i_stu = 1'b0;
        dones = 0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                if (b == 0) chk_beat($sformatf("ws.b0.%0d", k), vs.a0, vs.m0, vs.d0);
                else        chk_beat($sformatf("ws.b1.%0d", k), vs.a1, vs.m1, vs.d1);
                bus.valid_i_stu   = (b == 0 && k == 1);
                bus.addr_i_stu    = 64'h40;
                bus.data_i_stu    = 64'h77;
                bus.size_i_stu    = 2'd0;
                bus.mem_ack_i_stu = (k == 3);
                @(negedge clk);
                if (bus.done_o_stu) dones++;
            end
        end
        bus.mem_ack_i_stu = 1'b0;
        chk_done("ws");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done_o_stu) dones++;
            chk($sformatf("ws.idle%0d.req", k), 64'(bus.mem_req_o_stu), 64'd0);
            chk($sformatf("ws.idle%0d.rdy", k), 64'(bus.ready_o_stu), 64'd1);
        end
        chk("ws.done_count", 64'(dones), 64'd1);

        // Reset while beat1 waits for ack.
        bus.valid_i_stu = 1'b1;
        bus.addr_i_stu  = vs.addr;
        bus.data_i_stu  = vs.data;
        bus.size_i_stu  = vs.size;
        @(negedge clk);
        bus.valid_i_stu   = 1'b0;
        bus.mem_ack_i_stu = 1'b1;
        chk_beat("rm.b0", vs.a0, vs.m0, vs.d0);
        @(negedge clk);
        bus.mem_ack_i_stu = 1'b0;
        chk_beat("rm.b1", vs.a1, vs.m1, vs.d1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rm.req",   64'(bus.mem_req_o_stu), 64'd0);
        chk("rm.mask",  64'(bus.mem_wmask_o_stu), 64'd0);
        chk("rm.addr",  bus.mem_addr_o_stu, 64'd0);
        chk("rm.ready", 64'(bus.ready_o_stu), 64'd1);
        chk("rm.done",  64'(bus.done_o_stu), 64'd0);
        @(negedge clk);
        chk("rm.done2", 64'(bus.done_o_stu), 64'd0);
        bus.mem_ack_i_stu = 1'b1;
        run_vec("rm.sh", vt[9]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
